// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - command and status encodings shared by the FIFO and its benches
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        RSVD  = 2'd3
    } op_type;

    typedef enum logic [2:0] {
        EMPTY     = 3'd0,
        PARTIAL   = 3'd1,
        FULL      = 3'd2,
        OVERFLOW  = 3'd3,
        UNDERFLOW = 3'd4
    } status_type;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x WIDTH register array, one synchronous write and one registered read port
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_data;

    // Storage is deliberately left out of reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo.sv
// rtl/fifo.sv - op-driven single-clock FIFO; FIFO_ERROR_STATUS_EN enables OVERFLOW/UNDERFLOW reporting
module fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] wr_data,
    input  op_type           op,
    output logic [WIDTH-1:0] r_data,
    output status_type       status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    status_type    r_status;

    logic          w_full;
    logic          w_empty;
    logic          w_wr;
    logic          w_rd;
    logic          w_overflow;
    logic          w_underflow;
    logic [CW-1:0] w_count_next;
    status_type    w_status_next;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_wr    = (op == WRITE) && !w_full;
    assign w_rd    = (op == READ) && !w_empty;

`ifdef FIFO_ERROR_STATUS_EN
    assign w_overflow  = (op == WRITE) && w_full;
    assign w_underflow = (op == READ) && w_empty;
`else
    assign w_overflow  = 1'b0;
    assign w_underflow = 1'b0;
`endif

    always_comb begin
        w_count_next = r_count;
        if (w_wr) begin
            w_count_next = r_count + CW'(1);
        end else if (w_rd) begin
            w_count_next = r_count - CW'(1);
        end

        // Errors win for one cycle; otherwise status follows the post-edge occupancy.
        if (w_overflow) begin
            w_status_next = OVERFLOW;
        end else if (w_underflow) begin
            w_status_next = UNDERFLOW;
        end else if (w_count_next == '0) begin
            w_status_next = EMPTY;
        end else if (w_count_next == FULL_CNT) begin
            w_status_next = FULL;
        end else begin
            w_status_next = PARTIAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_status <= EMPTY;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count  <= w_count_next;
            r_status <= w_status_next;
        end
    end

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (wr_data),
        .rd_en   (w_rd),
        .rd_addr (r_rd_ptr),
        .rd_data (r_data)
    );

    assign status = r_status;

endmodule

// File: tb/tb_fifo.sv
// tb/tb_fifo.sv - self-checking bench for fifo; expectations track FIFO_ERROR_STATUS_EN
module tb_fifo;
    import fifo_pkg::*;

    localparam int DEPTH = 16;

`ifdef FIFO_ERROR_STATUS_EN
    localparam status_type OF_ST = OVERFLOW;
    localparam status_type UF_ST = UNDERFLOW;
`else
    localparam status_type OF_ST = FULL;
    localparam status_type UF_ST = EMPTY;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    op_type     op;
    logic [7:0] r_data;
    status_type status;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] q [$];
    logic [7:0] m_rd;
    status_type m_st;

    typedef struct {
        logic       rst;
        op_type     op;
        logic [7:0] din;
        logic [7:0] exp_data;
        status_type exp_st;
    } vec_t;

    vec_t vecs [12];

    fifo #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_data (wr_data),
        .op      (op),
        .r_data  (r_data),
        .status  (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // Inputs change at the falling edge; outputs are sampled 5 ns after the rising edge.
    task automatic step(input logic r, input op_type o, input logic [7:0] d);
        rst     = r;
        op      = o;
        wr_data = d;
        @(posedge clk);
        #5;
    endtask

    function automatic status_type occ();
        if (q.size() == 0) return EMPTY;
        if (q.size() == DEPTH) return FULL;
        return PARTIAL;
    endfunction

    task automatic mstep(input string nm, input op_type o, input logic [7:0] d);
        if (o == WRITE) begin
            if (q.size() < DEPTH) begin
                q.push_back(d);
                m_st = occ();
            end else begin
                m_st = OF_ST;
            end
        end else if (o == READ) begin
            if (q.size() > 0) begin
                m_rd = q.pop_front();
                m_st = occ();
            end else begin
                m_st = UF_ST;
            end
        end else begin
            m_st = occ();
        end
        step(1'b0, o, d);
        chk({nm, "_data"}, int'(r_data), int'(m_rd));
        chk({nm, "_status"}, int'(status), int'(m_st));
    endtask

    initial begin
        vecs[0]  = '{1'b1, IDLE,  8'h00, 8'h00, EMPTY};
        vecs[1]  = '{1'b1, WRITE, 8'h5A, 8'h00, EMPTY};
        vecs[2]  = '{1'b0, IDLE,  8'h00, 8'h00, EMPTY};
        vecs[3]  = '{1'b0, WRITE, 8'h11, 8'h00, PARTIAL};
        vecs[4]  = '{1'b0, WRITE, 8'h22, 8'h00, PARTIAL};
        vecs[5]  = '{1'b0, WRITE, 8'h33, 8'h00, PARTIAL};
        vecs[6]  = '{1'b0, READ,  8'h00, 8'h11, PARTIAL};
        vecs[7]  = '{1'b0, READ,  8'h00, 8'h22, PARTIAL};
        vecs[8]  = '{1'b0, READ,  8'h00, 8'h33, EMPTY};
        vecs[9]  = '{1'b0, READ,  8'h00, 8'h33, UF_ST};
        vecs[10] = '{1'b0, RSVD,  8'h77, 8'h33, EMPTY};
        vecs[11] = '{1'b0, IDLE,  8'h00, 8'h33, EMPTY};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].rst, vecs[i].op, vecs[i].din);
            chk($sformatf("vec%0d_data", i), int'(r_data), int'(vecs[i].exp_data));
            chk($sformatf("vec%0d_status", i), int'(status), int'(vecs[i].exp_st));
        end

        // Fill from pointer 3 so the write pointer wraps while filling.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, WRITE, 8'(i));
            chk($sformatf("fill%0d_status", i), int'(status), int'((i == DEPTH - 1) ? FULL : PARTIAL));
        end
        step(1'b0, WRITE, 8'hAA);
        chk("overflow_status", int'(status), int'(OF_ST));
        chk("overflow_data", int'(r_data), 8'h33);
        step(1'b0, IDLE, 8'h00);
        chk("after_overflow_status", int'(status), int'(FULL));
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, READ, 8'h00);
            chk($sformatf("drain%0d_data", i), int'(r_data), i);
            chk($sformatf("drain%0d_status", i), int'(status), int'((i == DEPTH - 1) ? EMPTY : PARTIAL));
        end
        step(1'b0, READ, 8'h00);
        chk("underflow_status", int'(status), int'(UF_ST));
        chk("underflow_data", int'(r_data), 8'h0F);
        step(1'b0, IDLE, 8'h00);
        chk("after_underflow_status", int'(status), int'(EMPTY));

        // Move both pointers to 13 so the random phase crosses 15 -> 0.
        q.delete();
        m_rd = 8'h0F;
        for (int i = 0; i < 10; i++) begin
            mstep($sformatf("pre_w%0d", i), WRITE, 8'(8'hC0 + i));
            mstep($sformatf("pre_r%0d", i), READ, 8'h00);
        end
        for (int i = 0; i < 40; i++) begin
            int     sel;
            op_type o;
            sel = int'($urandom_range(0, 99));
            if (sel < 55) o = WRITE;
            else if (sel < 90) o = READ;
            else if (sel < 95) o = IDLE;
            else o = RSVD;
            mstep($sformatf("rand%0d", i), o, 8'($urandom_range(0, 255)));
        end

        // Mid-operation reset discards stored entries.
        step(1'b1, IDLE, 8'h00);
        q.delete();
        m_rd = 8'h00;
        chk("rst_clear_status", int'(status), int'(EMPTY));
        for (int i = 0; i < 5; i++) begin
            mstep($sformatf("mid_w%0d", i), WRITE, 8'(8'h50 + i));
        end
        step(1'b1, WRITE, 8'hEE);
        chk("midrst_status", int'(status), int'(EMPTY));
        chk("midrst_data", int'(r_data), 0);
        step(1'b0, READ, 8'h00);
        chk("midrst_read_status", int'(status), int'(UF_ST));
        chk("midrst_read_data", int'(r_data), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
